// File: rtl/cmm_arbiter_if.sv
// Handshake bundle for cmm_arbiter: requester side, shared result bus and datapath side.
// slave is the arbiter's view; master is the requester/datapath environment's view.
interface cmm_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int SIZE    = 8,
  parameter int WIDTH   = 64
);
  logic                                        flush_i;
  logic [NUM_REQ-1:0]                          req_valid_i;
  logic [NUM_REQ-1:0]                          req_ready_o;
  logic [NUM_REQ-1:0][4*SIZE-1:0][WIDTH-1:0]   req_operands_i;
  logic [NUM_REQ-1:0]                          rsp_valid_o;
  logic [NUM_REQ-1:0]                          rsp_ready_i;
  logic [2*SIZE-1:0][WIDTH-1:0]                rsp_result_o;
  logic                                        dp_in_valid_o;
  logic                                        dp_in_ready_i;
  logic [4*SIZE-1:0][WIDTH-1:0]                dp_operands_o;
  logic                                        dp_flush_o;
  logic [2*SIZE-1:0][WIDTH-1:0]                dp_result_i;
  logic                                        dp_out_valid_i;
  logic                                        dp_out_ready_o;
  logic                                        busy_o;
  logic                                        err_o;

  modport slave (
    input  flush_i, req_valid_i, req_operands_i, rsp_ready_i,
           dp_in_ready_i, dp_result_i, dp_out_valid_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, dp_in_valid_o,
           dp_operands_o, dp_flush_o, dp_out_ready_o, busy_o, err_o
  );

  modport master (
    output flush_i, req_valid_i, req_operands_i, rsp_ready_i,
           dp_in_ready_i, dp_result_i, dp_out_valid_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, dp_in_valid_o,
           dp_operands_o, dp_flush_o, dp_out_ready_o, busy_o, err_o
  );
endinterface

// File: rtl/cmm_arbiter.sv
// Round-robin share of one complex_matrix_mul; zero-latency grant and in-order result routing via an ID FIFO.
// Issue stalls on full FIFO or flush; results back-pressured per owner. CMM_ARB_PERF_CNT_EN adds issue counters.
module cmm_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int SIZE         = 8,
  parameter int WIDTH        = 64,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
`ifdef CMM_ARB_PERF_CNT_EN
  output logic [NUM_REQ-1:0][15:0] issue_cnt_o,
`endif
  cmm_arbiter_if.slave             bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW  = PW + 1;

  logic [IDW-1:0] r_rr_ptr;
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_err;
  logic [IDW-1:0] r_id_mem [MAX_INFLIGHT];

  logic           w_gnt_vld;
  logic [IDW-1:0] w_gnt_idx;
  logic [IDW-1:0] w_rr_next;
  logic [IDW-1:0] w_head;
  logic           w_full;
  logic           w_empty;
  logic           w_issue_ok;
  logic           w_push;
  logic           w_pop;

  always_comb begin
    int idx;
    idx       = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_gnt_vld && bus.req_valid_i[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = IDW'(idx);
      end
    end
  end

  assign w_rr_next  = (w_gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_full     = (r_count == CW'(MAX_INFLIGHT));
  assign w_empty    = (r_count == '0);
  assign w_head     = r_id_mem[r_rd_ptr];
  // Reset gating keeps every handshake output quiet while rst_i is high.
  assign w_issue_ok = w_gnt_vld && !w_full && !bus.flush_i && !rst_i;
  assign w_push     = w_issue_ok && bus.dp_in_ready_i;
  assign w_pop      = bus.dp_out_valid_i && bus.dp_out_ready_o && !w_empty;

  assign bus.dp_in_valid_o  = w_issue_ok;
  assign bus.dp_operands_o  = bus.req_operands_i[w_gnt_idx];
  assign bus.req_ready_o    = w_push ? (NUM_REQ'(1) << w_gnt_idx) : '0;
  assign bus.dp_flush_o     = bus.flush_i && !rst_i;
  assign bus.rsp_result_o   = bus.dp_result_i;
  assign bus.rsp_valid_o    = (bus.dp_out_valid_i && !w_empty && !rst_i) ? (NUM_REQ'(1) << w_head) : '0;
  // With no owner on record, accept stray results so the datapath drains.
  assign bus.dp_out_ready_o = rst_i   ? 1'b0 :
                              w_empty ? bus.dp_out_valid_i :
                                        bus.rsp_ready_i[w_head];
  assign bus.busy_o         = !w_empty;
  assign bus.err_o          = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (bus.dp_out_valid_i && w_empty) begin
        r_err <= 1'b1;
      end
      if (bus.flush_i) begin
        r_rr_ptr <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_rr_ptr <= w_rr_next;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_id_mem[r_wr_ptr] <= w_gnt_idx;
    end
  end

`ifdef CMM_ARB_PERF_CNT_EN
  logic [NUM_REQ-1:0][15:0] r_issue_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_issue_cnt <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (w_push && (w_gnt_idx == IDW'(r)) && (r_issue_cnt[r] != 16'hFFFF)) begin
          r_issue_cnt[r] <= r_issue_cnt[r] + 16'd1;
        end
      end
    end
  end

  assign issue_cnt_o = r_issue_cnt;
`endif
endmodule

// File: tb/tb_cmm_arbiter.sv
// Directed bench for cmm_arbiter with a behavioural dot-product datapath model.
module tb_cmm_arbiter;
  logic clk;
  logic rst;
  logic model_en;
  logic man_vld;
  int   total;
  int   bad;

  cmm_arbiter_if #(.NUM_REQ(4), .SIZE(8), .WIDTH(64)) bus ();

`ifdef CMM_ARB_PERF_CNT_EN
  logic [3:0][15:0] issue_cnt;
  cmm_arbiter #(.NUM_REQ(4), .SIZE(8), .WIDTH(64), .MAX_INFLIGHT(4)) dut (
    .clk_i(clk), .rst_i(rst), .issue_cnt_o(issue_cnt), .bus(bus));
`else
  cmm_arbiter #(.NUM_REQ(4), .SIZE(8), .WIDTH(64), .MAX_INFLIGHT(4)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: one-cycle latency, elastic result queue, dot product of a and b.
  logic [63:0] m_re [16];
  logic [63:0] m_im [16];
  int          m_wr;
  int          m_rd;

  function automatic real dot_re(input logic [31:0][63:0] ops);
    real s = 0.0;
    for (int e = 0; e < 8; e++)
      s += $bitstoreal(ops[4*e]) * $bitstoreal(ops[4*e+2]) - $bitstoreal(ops[4*e+1]) * $bitstoreal(ops[4*e+3]);
    return s;
  endfunction

  function automatic real dot_im(input logic [31:0][63:0] ops);
    real s = 0.0;
    for (int e = 0; e < 8; e++)
      s += $bitstoreal(ops[4*e]) * $bitstoreal(ops[4*e+3]) + $bitstoreal(ops[4*e+1]) * $bitstoreal(ops[4*e+2]);
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wr <= 0;
      m_rd <= 0;
    end else if (bus.dp_flush_o) begin
      m_rd <= m_wr;
    end else begin
      if (bus.dp_in_valid_o && bus.dp_in_ready_i) begin
        m_re[m_wr[3:0]] <= $realtobits(dot_re(bus.dp_operands_o));
        m_im[m_wr[3:0]] <= $realtobits(dot_im(bus.dp_operands_o));
        m_wr <= m_wr + 1;
      end
      if (model_en && bus.dp_out_valid_i && bus.dp_out_ready_o)
        m_rd <= m_rd + 1;
    end
  end

  assign bus.dp_out_valid_i = model_en ? (m_wr != m_rd) : man_vld;

  always_comb begin
    bus.dp_result_i    = '0;
    bus.dp_result_i[0] = m_re[m_rd[3:0]];
    bus.dp_result_i[1] = m_im[m_rd[3:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int r, input real ar, input real ai, input real br, input real bi);
    for (int e = 0; e < 8; e++) begin
      bus.req_operands_i[r][4*e]   = $realtobits(ar);
      bus.req_operands_i[r][4*e+1] = $realtobits(ai);
      bus.req_operands_i[r][4*e+2] = $realtobits(br);
      bus.req_operands_i[r][4*e+3] = $realtobits(bi);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    // Reset with hostile inputs: every output must stay quiet.
    rst = 1'b1;
    model_en = 1'b0;
    man_vld = 1'b1;
    bus.flush_i = 1'b1;
    bus.req_valid_i = 4'hF;
    bus.rsp_ready_i = 4'hF;
    bus.dp_in_ready_i = 1'b1;
    bus.req_operands_i = '0;
    #1;
    chk("rst_dp_in_valid", 64'(bus.dp_in_valid_o), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst_dp_out_ready", 64'(bus.dp_out_ready_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_dp_flush", 64'(bus.dp_flush_o), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    man_vld = 1'b0;
    bus.flush_i = 1'b0;
    bus.req_valid_i = 4'h0;
    bus.rsp_ready_i = 4'h0;
    tick();
    tick();
    rst = 1'b0;
    model_en = 1'b1;
    tick();

    // Single request from requester 2: (1+2j)*(3+4j) summed over 8 elements.
    set_ops(2, 1.0, 2.0, 3.0, 4.0);
    bus.req_valid_i = 4'b0100;
    #1;
    chk("single_req_ready", 64'(bus.req_ready_o), 64'h4);
    chk("single_dp_in_valid", 64'(bus.dp_in_valid_o), 64'd1);
    chk("single_ops_aim", bus.dp_operands_o[1], $realtobits(2.0));
    chk("single_ops_bim", bus.dp_operands_o[3], $realtobits(4.0));
    tick();
    bus.req_valid_i = 4'b0000;
    bus.rsp_ready_i = 4'b0100;
    #1;
    chk("single_ready_once", 64'(bus.req_ready_o), 64'd0);
    chk("single_busy", 64'(bus.busy_o), 64'd1);
    chk("single_rsp_valid", 64'(bus.rsp_valid_o), 64'h4);
    chk("single_dp_out_ready", 64'(bus.dp_out_ready_o), 64'd1);
    chk("single_re", bus.rsp_result_o[0], $realtobits(-40.0));
    chk("single_im", bus.rsp_result_o[1], $realtobits(80.0));
    tick();
    chk("single_idle_busy", 64'(bus.busy_o), 64'd0);
    chk("single_idle_rsp", 64'(bus.rsp_valid_o), 64'd0);

    // Mid-run reset pulse, then all four requesters contend for 8 issues.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 4; r++) set_ops(r, real'(r + 1), 0.0, 1.0, 0.0);
    bus.req_valid_i = 4'hF;
    bus.rsp_ready_i = 4'hF;
    for (int i = 0; i <= 8; i++) begin
      if (i == 8) bus.req_valid_i = 4'h0;
      #1;
      if (i < 8) chk("rr_grant", 64'(bus.req_ready_o), 64'(1) << (i % 4));
      if (i > 0) begin
        chk("rr_rsp_route", 64'(bus.rsp_valid_o), 64'(1) << ((i - 1) % 4));
        chk("rr_rsp_data", bus.rsp_result_o[0], $realtobits(8.0 * real'((i - 1) % 4 + 1)));
      end
      tick();
    end
    chk("rr_drained", 64'(bus.busy_o), 64'd0);

    // Stall output until four are in flight.
    bus.rsp_ready_i = 4'h0;
    bus.req_valid_i = 4'hF;
    for (int i = 0; i < 4; i++) tick();
    chk("full_busy", 64'(bus.busy_o), 64'd1);
    chk("full_no_issue", 64'(bus.dp_in_valid_o), 64'd0);
    chk("full_no_grant", 64'(bus.req_ready_o), 64'd0);
    bus.rsp_ready_i = 4'hF;
    #1;
    chk("full_pop_rsp", 64'(bus.rsp_valid_o), 64'h1);
    chk("full_pop_ready", 64'(bus.dp_out_ready_o), 64'd1);
    chk("full_pop_no_push", 64'(bus.req_ready_o), 64'd0);
    tick();
    chk("after_pop_grant", 64'(bus.req_ready_o), 64'h1);
    chk("after_pop_rsp", 64'(bus.rsp_valid_o), 64'h2);
    chk("after_pop_data", bus.rsp_result_o[0], $realtobits(16.0));
    bus.req_valid_i = 4'h0;
    for (int i = 0; i < 4; i++) tick();
    chk("full_drained", 64'(bus.busy_o), 64'd0);

    // Three in flight (ids 1,2,1), then flush.
    bus.rsp_ready_i = 4'h0;
    bus.req_valid_i = 4'b0110;
    #1;
    chk("wrap_grant0", 64'(bus.req_ready_o), 64'h2);
    tick();
    chk("wrap_grant1", 64'(bus.req_ready_o), 64'h4);
    tick();
    chk("wrap_grant2", 64'(bus.req_ready_o), 64'h2);
    tick();
    chk("pre_flush_busy", 64'(bus.busy_o), 64'd1);
    bus.req_valid_i = 4'hF;
    bus.flush_i = 1'b1;
    #1;
    chk("flush_dp_flush", 64'(bus.dp_flush_o), 64'd1);
    chk("flush_blocks_issue", 64'(bus.dp_in_valid_o), 64'd0);
    chk("flush_no_grant", 64'(bus.req_ready_o), 64'd0);
    tick();
    bus.flush_i = 1'b0;
    #1;
    chk("post_flush_busy", 64'(bus.busy_o), 64'd0);
    chk("post_flush_err", 64'(bus.err_o), 64'd0);
    chk("post_flush_ptr0", 64'(bus.req_ready_o), 64'h1);
    bus.req_valid_i = 4'h0;
    tick();

    // Stray datapath result with nothing in flight.
    model_en = 1'b0;
    man_vld = 1'b1;
    bus.rsp_ready_i = 4'h0;
    #1;
    chk("stray_dp_out_ready", 64'(bus.dp_out_ready_o), 64'd1);
    chk("stray_no_rsp", 64'(bus.rsp_valid_o), 64'd0);
    chk("stray_err_before", 64'(bus.err_o), 64'd0);
    tick();
    man_vld = 1'b0;
    chk("stray_err_set", 64'(bus.err_o), 64'd1);
    tick();
    chk("stray_err_held", 64'(bus.err_o), 64'd1);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("err_survives_flush", 64'(bus.err_o), 64'd1);
    rst = 1'b1;
    #1;
    chk("err_async_clear", 64'(bus.err_o), 64'd0);
    tick();
    rst = 1'b0;
    man_vld = 1'b1;
    tick();
    man_vld = 1'b0;
    chk("late_result_err", 64'(bus.err_o), 64'd1);

`ifdef CMM_ARB_PERF_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_en = 1'b1;
    bus.rsp_ready_i = 4'hF;
    bus.req_valid_i = 4'b0001;
    for (int i = 0; i < 70000; i++) tick();
    bus.req_valid_i = 4'b0000;
    tick();
    tick();
    chk("cnt_sat_0", 64'(issue_cnt[0]), 64'hFFFF);
    chk("cnt_1", 64'(issue_cnt[1]), 64'd0);
    chk("cnt_2", 64'(issue_cnt[2]), 64'd0);
    chk("cnt_3", 64'(issue_cnt[3]), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
